crossing_request: RTL and testbench
===================================

# crossing_request

Pedestrian-side request unit for the crossing controller. It synchronises and debounces the raw push-button, and holds the controller's `start` request until the crossing-green aspect appears on `lightseq`. It drives the WAIT lamp and an optional audible crossing cue. It sits between the kerbside button panel and the `start`/`lightseq` pins of the light-sequence controller, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised-high cycles before a press is recognised; legal range 1..255.
- `BEEP_HALF_PERIOD`, 2: cycles per half-period of the `beep` square wave; legal range ≥1.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `button`  in  1  raw pedestrian push-button; asynchronous and bouncy.
- `lightseq`  in  6  light aspects from the controller, same clock domain.
  - [5:3] traffic R/A/G.
  - [2] crossing red.
  - [1] unused.
  - [0] crossing green.
- `start`  out  1  request to the controller; level, held until served.
- `wait_lamp`  out  1  WAIT indicator; equals `start`.
- `beep`  out  1  audible cue during crossing green.
- `req_count`  out  8  number of served requests; saturates at 255.

## Operation
- Button path:
  - Two-flop synchroniser gives `btn_s`.
  - An 8-bit counter counts consecutive cycles with `btn_s`=1 and clears when `btn_s`=0.
  - `deb` is registered: it is 1 when the counter has reached DEBOUNCE_CYCLES and `btn_s`=1.
  - `press` = `deb` & ~`deb_d`, a one-cycle pulse.
- FSM states are IDLE, REQ and CROSS. Reset state is IDLE.
  - IDLE: if `lightseq[0]`=1, go to CROSS; this has priority over `press`. Otherwise, if `press`=1, go to REQ.
  - REQ: if `lightseq[0]`=1, go to CROSS and increment `req_count` (saturating). Otherwise stay in REQ. Further presses in REQ have no effect.
  - CROSS: if `lightseq[0]`=0, go to IDLE. Presses while in CROSS are discarded, not latched.
- Outputs:
  - `start` = `wait_lamp` = (state==REQ), Moore-decoded.
  - `beep` is 0 outside CROSS.
- `lightseq` bits [5:1] are not interpreted.
- A button held continuously produces exactly one `press`. A new press needs `btn_s` to fall and then re-qualify.

## Timing
- Reset (asynchronous, `reset`=0) forces:
  - `start`=0, `wait_lamp`=0, `beep`=0, `req_count`=0.
  - FSM to IDLE.
  - Synchroniser, counter, `deb`, `deb_d` and beep divider to 0.
- Reset mid-REQ drops `start` without waiting for a clock edge.
- Press latency: `button` rises before edge 1 and is held. Then:
  - `btn_s`=1 after edge 2.
  - `deb`=1 after edge 2+DEBOUNCE_CYCLES.
  - `start`=1 after edge 3+DEBOUNCE_CYCLES.
- Release latency: `start` falls after the first edge at which `lightseq[0]`=1 is sampled in REQ, i.e. 1 cycle after crossing green appears.
- `req_count` updates on that same edge.
- Bounce: any `btn_s`=0 sample restarts qualification from zero.
- Simultaneous `press` and `lightseq[0]` rise in IDLE: go to CROSS. No request is latched and `req_count` is unchanged.

## Configuration
- `CROSSING_BEEP_EN` defined:
  - In CROSS, a divider toggles `beep` every BEEP_HALF_PERIOD cycles.
  - The first toggle to 1 occurs BEEP_HALF_PERIOD edges after CROSS entry.
  - On leaving CROSS, the divider and `beep` clear to 0 on the same edge.
- `CROSSING_BEEP_EN` undefined:
  - `beep` is tied to 0 and the divider is not built.
  - The port remains present.

## Structure
- Package `crossing_pkg` holds:
  - The state typedef (IDLE/REQ/CROSS).
  - Lightseq bit-index constants: `LS_XING_GREEN`=0, `LS_XING_RED`=2, `LS_TRAFFIC_R`=5, `LS_TRAFFIC_A`=4, `LS_TRAFFIC_G`=3.
  - `REQ_COUNT_MAX`=255.
- Sub-module `button_debounce` contains the synchroniser, qualification counter and `deb`/`press` generation. It is parameterised by DEBOUNCE_CYCLES and outputs `press`.

## Test plan
- Reset release, `button` held 1, `lightseq`=6'b001100, DEBOUNCE_CYCLES=4 → `start`=`wait_lamp`=1 after edge 7; still 1 after 20 further cycles.
- Bounce 1,0,1,1,0 on `button`, then steady 1 → no `press` until 4 consecutive synchronised 1s. Exactly one REQ entry.
- In REQ, `lightseq` changes to 6'b100001 → `start`=0 after next edge. `req_count` goes 0→1. With `CROSSING_BEEP_EN`, `beep` toggles every 2 cycles. When `lightseq` returns to 6'b001100, `beep`=0 and state is IDLE.
- Press during CROSS (`lightseq`=6'b100001) → `start` stays 0, including after `lightseq` returns to 6'b001100.
- `reset`=0 asserted mid-REQ between edges → `start`, `wait_lamp`, `req_count` = 0 immediately. After release, IDLE with `start`=0 while `button`=0.
- 256 served requests → `req_count` reads 255 and holds.

Source files
------------

// File: rtl/crossing_request_pkg.sv
// Shared types and constants for the pedestrian crossing request unit.
// Holds the FSM state encoding, lightseq bit positions, the served-request ceiling and a saturating-increment helper.
package crossing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CROSS = 2'd2
    } state_t;

    localparam int LS_XING_GREEN = 0;
    localparam int LS_XING_RED   = 2;
    localparam int LS_TRAFFIC_G  = 3;
    localparam int LS_TRAFFIC_A  = 4;
    localparam int LS_TRAFFIC_R  = 5;

    localparam logic [7:0] REQ_COUNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == REQ_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/crossing_request_if.sv
// Button-panel / controller-side signal bundle of the crossing request unit.
// The slave modport is the request unit; the master modport is whatever drives the button and lightseq.
interface crossing_request_if;
    logic       button;
    logic [5:0] lightseq;
    logic       start;
    logic       wait_lamp;
    logic       beep;
    logic [7:0] req_count;

    modport master (output button, lightseq, input start, wait_lamp, beep, req_count);
    modport slave  (input button, lightseq, output start, wait_lamp, beep, req_count);
endinterface

// File: rtl/crossing_request_debounce.sv
// Synchronise and debounce the raw button into a single-cycle press pulse.
// Latency: press visible DEBOUNCE_CYCLES+2 edges after the button is first sampled high; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    logic       sync_a;
    logic       btn_s;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       deb;
    logic       deb_d;

    // Run length of synchronised-high cycles; saturates so a long hold never wraps and re-fires.
    always_comb begin
        cnt_nxt = 8'd0;
        if (btn_s) begin
            cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
            cnt    <= 8'd0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
        end else begin
            sync_a <= button;
            btn_s  <= sync_a;
            cnt    <= cnt_nxt;
            deb    <= btn_s && (cnt_nxt >= 8'(DEBOUNCE_CYCLES));
            deb_d  <= deb;
        end
    end

    assign press = deb & ~deb_d;

endmodule

// File: rtl/crossing_request.sv
// Pedestrian request unit: holds start until crossing green, counts served requests, optional beep (CROSSING_BEEP_EN).
// Latency: start rises one edge after press, falls one edge after crossing green; no backpressure.
module crossing_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int BEEP_HALF_PERIOD = 2
) (
    input  logic               clock,
    input  logic               reset,
    crossing_request_if.slave  bus
);

    state_t     state;
    logic       start_q;
    logic [7:0] count;
    logic       press;
    logic       xing_green;
    logic       unused_ls;

    assign xing_green = bus.lightseq[LS_XING_GREEN];
    assign unused_ls  = ^bus.lightseq[5:1];

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .button(bus.button),
        .press (press)
    );

    // Crossing green outranks a coincident press, so a request is never latched during a crossing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (xing_green) begin
                        state   <= CROSS;
                        start_q <= 1'b0;
                    end else if (press) begin
                        state   <= REQ;
                        start_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (xing_green) begin
                        state   <= CROSS;
                        start_q <= 1'b0;
                        count   <= sat_inc(count);
                    end
                end
                CROSS: begin
                    if (!xing_green) begin
                        state   <= IDLE;
                        start_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start     = start_q;
    assign bus.wait_lamp = start_q;
    assign bus.req_count = count;

`ifdef CROSSING_BEEP_EN
    localparam int DIV_W = (BEEP_HALF_PERIOD > 1) ? $clog2(BEEP_HALF_PERIOD) : 1;

    logic [DIV_W-1:0] div;
    logic             beep_q;

    // Divider runs only while the crossing stays green; entry and exit both leave it cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div    <= '0;
            beep_q <= 1'b0;
        end else if (state == CROSS && xing_green) begin
            if (div == DIV_W'(BEEP_HALF_PERIOD - 1)) begin
                div    <= '0;
                beep_q <= ~beep_q;
            end else begin
                div <= div + DIV_W'(1);
            end
        end else begin
            div    <= '0;
            beep_q <= 1'b0;
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_crossing_request.sv
// Randomised scoreboard bench for crossing_request with a press/served-request reference model.
// Expected outputs are queued per clock edge and compared by an independent negedge monitor.
module tb_crossing_request;

    localparam int D = 4;
    localparam int H = 2;
    localparam logic [5:0] LS_IDLE  = 6'b001100;
    localparam logic [5:0] LS_GREEN = 6'b100001;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    crossing_request_if bus();

    crossing_request #(
        .DEBOUNCE_CYCLES (D),
        .BEEP_HALF_PERIOD(H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       start;
        logic       wait_lamp;
        logic       beep;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: run lengths of sampled button highs, plus request state in spec terms.
    int runq[$];
    int m_state;   // 0 idle, 1 requesting, 2 crossing
    int m_count;
    int m_t;       // edges spent in the current crossing

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        runq.delete();
        m_state = 0;
        m_count = 0;
        m_t     = 0;
    endtask

    task automatic model_edge(input logic b, input logic [5:0] ls);
        int   n;
        int   run;
        bit   p;
        exp_t e;
        if (b) run = (runq.size() > 0) ? runq[runq.size()-1] + 1 : 1;
        else   run = 0;
        runq.push_back(run);
        n = runq.size();
        // Button sampled at edge k is synchronised two edges later and qualified one edge after that.
        p = (n >= 4) && (runq[n-4] == D);
        case (m_state)
            0: if (ls[0]) begin m_state = 2; m_t = 0; end
               else if (p) m_state = 1;
            1: if (ls[0]) begin
                   m_state = 2;
                   m_t     = 0;
                   if (m_count < 255) m_count++;
               end
            default: if (!ls[0]) m_state = 0; else m_t++;
        endcase
        e.start     = (m_state == 1);
        e.wait_lamp = (m_state == 1);
`ifdef CROSSING_BEEP_EN
        e.beep      = (m_state == 2) && (((m_t / H) % 2) == 1);
`else
        e.beep      = 1'b0;
`endif
        e.cnt       = 8'(m_count);
        sb.push_back(e);
    endtask

    task automatic step(input logic b, input logic [5:0] ls);
        #1;
        bus.button   = b;
        bus.lightseq = ls;
        @(posedge clock);
        model_edge(b, ls);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("start",     bus.start,     mon_e.start);
            check("wait_lamp", bus.wait_lamp, mon_e.wait_lamp);
            check("beep",      bus.beep,      mon_e.beep);
            check("req_count", bus.req_count, mon_e.cnt);
        end
    end

    initial begin
        logic [31:0] r;
        logic        lvl;
        logic [5:0]  ls;
        int          len;

        bus.button   = 1'b0;
        bus.lightseq = LS_IDLE;
        model_reset();
        #3;
        check("rst_start",     bus.start,     0);
        check("rst_wait_lamp", bus.wait_lamp, 0);
        check("rst_beep",      bus.beep,      0);
        check("rst_req_count", bus.req_count, 0);
        #9 reset = 1'b1;

        // Held press: start appears after edge 3+D and stays.
        repeat (D + 2) step(1'b1, LS_IDLE);
        #1 check("start_before_e7", bus.start, 0);
        step(1'b1, LS_IDLE);
        #1 check("start_at_e7", bus.start, 1);
        repeat (20) step(1'b1, LS_IDLE);

        // Crossing green serves the request, then back to idle.
        repeat (10) step(1'b0, LS_GREEN);
        repeat (6)  step(1'b0, LS_IDLE);

        // Bounce then steady high.
        step(1'b1, LS_IDLE); step(1'b0, LS_IDLE); step(1'b1, LS_IDLE);
        step(1'b1, LS_IDLE); step(1'b0, LS_IDLE);
        repeat (12) step(1'b1, LS_IDLE);
        #1 check("bounce_req", bus.start, 1);
        repeat (5) step(1'b0, LS_GREEN);
        repeat (3) step(1'b0, LS_IDLE);

        // Press during crossing is discarded.
        repeat (2)  step(1'b0, LS_GREEN);
        repeat (12) step(1'b1, LS_GREEN);
        repeat (3)  step(1'b0, LS_GREEN);
        repeat (10) step(1'b0, LS_IDLE);

        // Randomised segments of button level and lightseq aspects.
        repeat (250) begin
            r   = $urandom;
            lvl = r[0];
            len = $urandom_range(1, 10);
            ls  = {r[8:4], ($urandom_range(0, 4) == 0)};
            repeat (len) step(lvl, ls);
        end

        // Reset asserted between edges while requesting.
        repeat (3) step(1'b0, LS_IDLE);
        repeat (D + 4) step(1'b1, LS_IDLE);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_start",     bus.start,     0);
        check("mid_rst_wait_lamp", bus.wait_lamp, 0);
        check("mid_rst_req_count", bus.req_count, 0);
        check("mid_rst_beep",      bus.beep,      0);
        model_reset();
        bus.button = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        repeat (8) step(1'b0, LS_IDLE);

        // Saturation of the served-request counter.
        repeat (260) begin
            repeat (D + 4) step(1'b1, LS_IDLE);
            repeat (2)     step(1'b0, LS_GREEN);
            repeat (2)     step(1'b0, LS_IDLE);
        end
        #1 check("req_count_sat", bus.req_count, 255);

        @(negedge clock);
        #1 check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
